// File: rtl/fetch_queue.sv
// Purpose: rv32 instruction-fetch front end; issues sequential imem requests, queues returned words with PCs for decode.
// Latency: request accepted in cycle t, response in t+L, word visible on dec_* in t+L+1 (no response bypass).
// Backpressure: a credit count (queued + live in-flight) holds requests off so every non-stale response has a slot.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   imem_req_*           fetch request valid/ready/address
//   imem_rsp_*           in-order response valid/data (no ready: memory never stalls responses)
//   redirect_*           branch/jump restart; flushes the queue and marks in-flight responses stale
//   dec_*                queue head valid/instr/pc, decode ready
//   q_count              occupied queue entries
module fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       dec_valid,
  output logic [31:0]                dec_instr,
  output logic [XLEN-1:0]            dec_pc,
  input  logic                       dec_ready,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // count + inflight can reach DEPTH + MAX_OUTSTANDING <= 2*DEPTH, one extra bit covers it
  localparam int SW = CW + 1;

  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S  = SW'(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [OW-1:0]   inflight, stale;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic            req_fire, push, pop, rsp_drop;
  logic [SW-1:0]   credit;
  logic [OW-1:0]   stale_on_redirect;
  logic [XLEN-1:0] redirect_aligned;

  always_comb begin
    // stale <= inflight always, so this never underflows
    credit           = SW'(count) + SW'(inflight) - SW'(stale);
    imem_req_valid   = rst && !redirect_valid && (inflight < MAX_OUT) && (credit < DEPTH_S);
    imem_req_addr    = fetch_pc;
    req_fire         = imem_req_valid && imem_req_ready;
    rsp_drop         = imem_rsp_valid && (stale != '0);
    push             = imem_rsp_valid && (stale == '0) && !redirect_valid;
    dec_valid        = (count != '0);
    pop              = dec_valid && dec_ready && !redirect_valid;
    // storage is not reset, so the head is masked while the queue is empty
    dec_instr        = dec_valid ? instr_mem[head] : '0;
    dec_pc           = dec_valid ? pc_mem[head] : '0;
    q_count          = count;
    redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    // a response landing in the redirect cycle is itself dropped, everything else still out becomes stale
    stale_on_redirect = (imem_rsp_valid && inflight != '0) ? inflight - OW'(1) : inflight;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      stale    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_aligned;
      rsp_pc   <= redirect_aligned;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= stale_on_redirect;
      stale    <= stale_on_redirect;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) begin
        tail   <= tail + PW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) head <= head + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case ({req_fire, imem_rsp_valid})
        2'b10:   inflight <= inflight + OW'(1);
        2'b01:   inflight <= inflight - OW'(1);
        default: inflight <= inflight;
      endcase

      if (rsp_drop) stale <= stale - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= imem_rsp_data;
      pc_mem[tail]    <= rsp_pc;
    end
  end

  // A live response into a full queue means the memory returned more than was asked for.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && count == CNT_FULL));
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst) !(imem_rsp_valid && inflight == '0));
  a_inflight_bound: assert property (@(posedge clk) disable iff (!rst) inflight <= MAX_OUT && stale <= inflight);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic [2:0]  q_count;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .q_count(q_count)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    int   lat; bit rdy; bit rdy_rand; int ncyc;
    bit   chk_end; logic [2:0] exp_qcount; bit exp_req_valid; bit exp_dec_valid;
  } vec_t;

  mreq_t       pend[$];     // memory model: accepted requests not yet answered
  logic [31:0] exp_q[$];    // scoreboard: PCs decode must see, in order
  logic [31:0] exp_fetch;
  int          checks = 0, errors = 0;
  int          cyc, lat, npop, first_dv;
  bit          rdy, rdy_rand, popped;
  logic [31:0] last_pop_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // One clock: sample at negedge, then advance the memory model and drive next inputs just after posedge.
  task automatic tick();
    mreq_t       m;
    logic [31:0] e;
    int          outstanding;
    @(negedge clk);
    if (first_dv < 0 && dec_valid) first_dv = cyc;
    if (dec_valid && dec_ready && !redirect_valid) begin
      popped      = 1'b1;
      last_pop_pc = dec_pc;
      npop++;
      if (exp_q.size() == 0) begin
        fail_bound("unexpected_pop");
        $display("FAIL unexpected_pop_pc: got %h want none", dec_pc);
      end else begin
        e = exp_q.pop_front();
        chk("dec_pc", dec_pc, e);
        chk("dec_instr", dec_instr, word_of(e));
      end
    end
    if (redirect_valid) begin
      chk("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end
    if (imem_req_valid && imem_req_ready) begin
      outstanding = pend.size() + (imem_rsp_valid ? 1 : 0);
      chk("outstanding_lt_max", 32'(outstanding < 2), 32'd1);
      chk("req_addr", imem_req_addr, exp_fetch);
      m.addr = imem_req_addr;
      m.due  = cyc + lat;
      pend.push_back(m);
      exp_q.push_back(imem_req_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    dec_ready      = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      m = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(m.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc);
    popped = 1'b0;
    for (int i = 0; i < 40 && !popped; i++) tick();
    if (!popped) fail_bound(name);
    else chk(name, last_pop_pc, exp_pc);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
  endtask

  vec_t vecs[6];
  int   n, start_pop;
  bit   ok;

  initial begin
    // lat rdy rr ncyc | chk q req dec
    vecs[0] = '{1, 1'b1, 1'b0, 20, 1'b1, 3'd1, 1'b1, 1'b1};  // steady one-per-cycle stream
    vecs[1] = '{1, 1'b0, 1'b0, 12, 1'b1, 3'd4, 1'b0, 1'b1};  // decode stall fills queue, fetch stops
    vecs[2] = '{1, 1'b1, 1'b0, 12, 1'b1, 3'd2, 1'b1, 1'b1};  // release: drains in order, refetch overlaps
    vecs[3] = '{3, 1'b1, 1'b0, 24, 1'b0, 3'd0, 1'b0, 1'b0};  // long latency, outstanding capped
    vecs[4] = '{2, 1'b1, 1'b1, 40, 1'b0, 3'd0, 1'b0, 1'b0};  // random decode stalls
    vecs[5] = '{1, 1'b1, 1'b1, 30, 1'b0, 3'd0, 1'b0, 1'b0};

    rst = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    cyc = 0; lat = 1; rdy = 1'b1; rdy_rand = 1'b0; npop = 0; first_dv = -1; exp_fetch = 32'h0;

    @(negedge clk);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);

    @(posedge clk); #1;
    rst = 1'b1; cyc = 1;
    repeat (6) tick();
    chk("first_dec_valid_cycle", 32'(first_dv), 32'd3);

    foreach (vecs[v]) begin
      lat = vecs[v].lat; rdy = vecs[v].rdy; rdy_rand = vecs[v].rdy_rand;
      dec_ready = rdy;
      repeat (vecs[v].ncyc) tick();
      if (vecs[v].chk_end) begin
        chk($sformatf("v%0d_q_count", v), 32'(q_count), 32'(vecs[v].exp_qcount));
        chk($sformatf("v%0d_req_valid", v), 32'(imem_req_valid), 32'(vecs[v].exp_req_valid));
        chk($sformatf("v%0d_dec_valid", v), 32'(dec_valid), 32'(vecs[v].exp_dec_valid));
      end
    end

    // Throughput with L=3 and two outstanding: window of 12 cycles.
    lat = 3; rdy = 1'b1; rdy_rand = 1'b0; dec_ready = 1'b1;
    repeat (12) tick();
    start_pop = npop;
    repeat (12) tick();
    n = npop - start_pop;
    chk("l3_throughput_in_range", 32'(n >= 6 && n <= 8), 32'd1);

    // Redirect with two requests in flight and no response this cycle.
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (pend.size() == 2 && !imem_rsp_valid) ok = 1'b1;
      else tick();
    end
    if (!ok) fail_bound("wait_two_inflight");
    do_redirect(32'h100);
    wait_pop("redir_first_pc", 32'h100);

    // Redirect in the same cycle as a response; low address bits ignored.
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (imem_rsp_valid) ok = 1'b1;
      else tick();
    end
    if (!ok) fail_bound("wait_rsp");
    do_redirect(32'h203);
    wait_pop("redir_rsp_pc0", 32'h200);
    wait_pop("redir_rsp_pc1", 32'h204);

    // Back-to-back redirects: last wins.
    do_redirect(32'h300);
    do_redirect(32'h400);
    wait_pop("b2b_redirect_pc", 32'h400);

    // Asynchronous reset mid-burst with three queued entries.
    rdy = 1'b0; dec_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (q_count == 3'd3) ok = 1'b1;
      else tick();
    end
    if (!ok) fail_bound("wait_q3");
    #1;
    rst = 1'b0;
    #1;
    chk("arst_dec_valid", 32'(dec_valid), 32'd0);
    chk("arst_q_count", 32'(q_count), 32'd0);
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_dec_pc", dec_pc, 32'd0);
    pend.delete(); exp_q.delete(); exp_fetch = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1; rdy = 1'b1; dec_ready = 1'b1;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);
    wait_pop("post_rst_first_pc", 32'h0);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
